row_accumulator: RTL and testbench

Downstream consumer of the matrix-vector controller's sequencing strobes. Takes the stream of signed products from the multiplier, accumulates one sum per matrix row using `zero_in` and `last`, and writes each finished row result into the result BRAM at a sequential row address. Signals `done` once the controller's `finish` has arrived and every in-flight result has been written.

---
 rtl/row_accumulator.sv | 232 +++++++++++++++++++++++
 tb/tb_row_accumulator.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_accumulator.sv
// row_accumulator
// Accumulates one signed sum per matrix row from the multiplier's product
// stream, framed by zero_in/last. Each finished row is written to the result
// BRAM at a sequential row address after DELAY_ACC pipeline stages. A job ends
// with a one-cycle done pulse once finish has arrived and every in-flight
// result has been written.
//
// Build option: define ROW_ACC_SAT_EN to clamp each row sum to the signed
// OUT_W range. Without it, the low OUT_W bits are written (two's-complement
// wrap). Latency is the same in both builds.
//
// Handshake: in_valid qualifies in_data/zero_in/last for exactly the cycle it
// is high. There is no back-pressure, so one sample can be taken every cycle.
// res_we is a one-cycle write strobe that qualifies res_addr/res_data.
module row_accumulator #(
  parameter int IN_W      = 12,
  parameter int ACC_W     = 21,
  parameter int OUT_W     = 16,
  parameter int ADDR_W    = 10,
  parameter int DELAY_ACC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic              zero_in,
  input  logic              last,
  input  logic              finish,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [OUT_W-1:0]  res_data,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_sext;
  logic signed [ACC_W-1:0] sum;
  logic [ADDR_W-1:0]       row_cnt;
  logic [ADDR_W-1:0]       row_base;
  logic [OUT_W-1:0]        res_word;

  logic seed;
  logic add;
  logic emit;
  logic proto_err;
  logic open_after;
  logic accepting;
  logic start_take;
  logic finish_take;
  logic finish_err;

  logic              tail_v;
  logic [ADDR_W-1:0] tail_addr;
  logic [OUT_W-1:0]  tail_data;
  logic              pipe_busy;

  assign in_sext     = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign accepting   = (state == S_IDLE) || (state == S_OPEN);
  assign start_take  = start && (state == S_IDLE);
  assign finish_take = finish && accepting;
  assign finish_err  = finish_take && open_after;
  assign sum         = seed ? in_sext : (acc + in_sext);
  // A start in the same cycle as an emitted row tags that row as row 0.
  assign row_base    = start_take ? '0 : row_cnt;

  // Decode the current sample against the row framing for this state.
  always_comb begin
    seed       = 1'b0;
    add        = 1'b0;
    emit       = 1'b0;
    proto_err  = 1'b0;
    open_after = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (zero_in) begin
            seed       = 1'b1;
            emit       = last;
            open_after = ~last;
          end else begin
            proto_err  = 1'b1;
          end
        end
      end
      S_OPEN: begin
        open_after = 1'b1;
        if (in_valid) begin
          if (zero_in) begin
            // Row restarted without last: reseed and keep the row open.
            seed      = 1'b1;
            proto_err = 1'b1;
          end else begin
            add        = 1'b1;
            emit       = last;
            open_after = ~last;
          end
        end
      end
      default: begin
        seed = 1'b0;
      end
    endcase
  end

  // Next-state selection; finish wins over row framing once the sample is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_OPEN: begin
        if (finish_take)     state_nxt = S_FLUSH;
        else if (open_after) state_nxt = S_OPEN;
        else                 state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        if (!pipe_busy)      state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef ROW_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W-1)));

  // Clamp the row sum to the signed result-word range.
  always_comb begin
    if (sum > SAT_MAX)      res_word = SAT_MAX[OUT_W-1:0];
    else if (sum < SAT_MIN) res_word = SAT_MIN[OUT_W-1:0];
    else                    res_word = sum[OUT_W-1:0];
  end
`else
  // Pass the low result-word bits straight through.
  always_comb begin
    res_word = sum[OUT_W-1:0];
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Accumulator: seeded by zero_in, otherwise summed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              acc <= '0;
    else if (seed || add) acc <= sum;
  end

  // Row counter advances once per emitted row and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       row_cnt <= '0;
    else if (emit) row_cnt <= row_base + ADDR_W'(1);
    else           row_cnt <= row_base;
  end

  // Sticky error: set by framing faults, cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err <= 1'b0;
    else if (proto_err || finish_err) err <= 1'b1;
    else if (start_take)              err <= 1'b0;
  end

  generate
    if (DELAY_ACC == 0) begin : g_direct
      assign tail_v    = emit;
      assign tail_addr = row_base;
      assign tail_data = res_word;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [DELAY_ACC-1:0] v_q;
      logic [ADDR_W-1:0]    a_q [DELAY_ACC];
      logic [OUT_W-1:0]     d_q [DELAY_ACC];

      // Result delay line carrying the tagged row sums.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          for (int i = 0; i < DELAY_ACC; i++) begin
            a_q[i] <= '0;
            d_q[i] <= '0;
          end
        end else begin
          v_q[0] <= emit;
          a_q[0] <= row_base;
          d_q[0] <= res_word;
          for (int i = 1; i < DELAY_ACC; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign tail_v    = v_q[DELAY_ACC-1];
      assign tail_addr = a_q[DELAY_ACC-1];
      assign tail_data = d_q[DELAY_ACC-1];
      assign pipe_busy = |v_q;
    end
  endgenerate

  // BRAM write port register; address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
    end else begin
      res_we <= tail_v;
      if (tail_v) begin
        res_addr <= tail_addr;
        res_data <= tail_data;
      end
    end
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_row_accumulator.sv
// Testbench for row_accumulator: directed and randomized jobs checked against
// a behavioural row-sum model with an expected-write queue.
module tb_row_accumulator;

  localparam int IN_W      = 12;
  localparam int ACC_W     = 21;
  localparam int OUT_W     = 16;
  localparam int ADDR_W    = 10;
  localparam int DELAY_ACC = 3;
  localparam int EW        = 32 + ADDR_W + OUT_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              zero_in;
  logic              last;
  logic              finish;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [OUT_W-1:0]  res_data;
  logic              done;
  logic              err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  logic [EW-1:0] exp_q[$];
  longint        m_sum   = 0;
  bit            m_open  = 0;
  bit            m_err   = 0;
  int            m_rows  = 0;
  int            fin_c   = -1;
  int            exp_done = -1;

  row_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .ADDR_W(ADDR_W), .DELAY_ACC(DELAY_ACC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .zero_in(zero_in), .last(last), .finish(finish),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .done(done), .err(err), .busy(busy)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result word as the BRAM should see it for a given exact row sum.
  function automatic logic [OUT_W-1:0] fmt(input longint s);
    longint hi;
    longint lo;
    longint r;
    hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lo = -(longint'(1) <<< (OUT_W-1));
    r  = s;
`ifdef ROW_ACC_SAT_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    if (hi < lo) r = 0;
`endif
    return r[OUT_W-1:0];
  endfunction

  // Behavioural model: exact row sums, a write expected 1+DELAY_ACC cycles
  // after the closing sample, and done one cycle after the last write.
  always @(posedge clk or posedge rst) begin : model
    longint v;
    if (rst) begin
      exp_q.delete();
      m_sum = 0; m_open = 0; m_err = 0; m_rows = 0;
      fin_c = -1; exp_done = -1;
    end else if (!(cyc > fin_c && cyc <= exp_done)) begin
      if (start) begin
        m_rows = 0;
        m_err  = 0;
      end
      if (in_valid) begin
        v = $signed(in_data);
        if (zero_in) begin
          if (m_open) begin
            m_err = 1;
            m_sum = v;
          end else if (last) begin
            m_sum = v;
            exp_q.push_back({32'(cyc + 1 + DELAY_ACC), m_rows[ADDR_W-1:0], fmt(m_sum)});
            m_rows++;
          end else begin
            m_sum  = v;
            m_open = 1;
          end
        end else if (!m_open) begin
          m_err = 1;
        end else begin
          m_sum = m_sum + v;
          if (last) begin
            exp_q.push_back({32'(cyc + 1 + DELAY_ACC), m_rows[ADDR_W-1:0], fmt(m_sum)});
            m_rows++;
            m_open = 0;
          end
        end
      end
      if (finish) begin
        if (m_open) begin
          m_err  = 1;
          m_open = 0;
        end
        fin_c    = cyc;
        exp_done = cyc + 2;
        if (exp_q.size() > 0 && int'(exp_q[exp_q.size()-1][EW-1 -: 32]) + 1 > exp_done)
          exp_done = int'(exp_q[exp_q.size()-1][EW-1 -: 32]) + 1;
      end
    end
  end

  // Scoreboard: every cycle compare the write port, done, err and busy.
  always @(negedge clk) begin : scoreboard
    logic [EW-1:0] h;
    bit            exp_we;
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
      h = exp_q.pop_front();
      check("missed_write", 64'(cyc), 64'(h[EW-1 -: 32]));
    end
    exp_we = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) == cyc);
    check("res_we", 64'(res_we), 64'(exp_we));
    if (exp_we) begin
      h = exp_q.pop_front();
      check("res_addr", 64'(res_addr), 64'(h[OUT_W +: ADDR_W]));
      check("res_data", 64'(res_data), 64'(h[OUT_W-1:0]));
    end
    check("done", 64'(done), 64'(cyc == exp_done));
    check("err", 64'(err), 64'(m_err));
    check("busy", 64'(busy), 64'(m_open || (cyc > fin_c && cyc <= exp_done)));
  end

  // Driver tasks
  task automatic send(input bit v, input bit z, input bit l, input logic [IN_W-1:0] d,
                      input bit s, input bit f);
    in_valid = v; zero_in = z; last = l; in_data = d; start = s; finish = f;
    @(posedge clk);
    #1;
    in_valid = 0; zero_in = 0; last = 0; in_data = '0; start = 0; finish = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) send(0, 0, 0, '0, 0, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (cyc <= exp_done && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_timeout", 64'(n < 200), 64'(1));
    idle(1);
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    check({tag, "_we"},   64'(res_we),   64'(0));
    check({tag, "_addr"}, 64'(res_addr), 64'(0));
    check({tag, "_data"}, 64'(res_data), 64'(0));
    check({tag, "_done"}, 64'(done),     64'(0));
    check({tag, "_err"},  64'(err),      64'(0));
    check({tag, "_busy"}, 64'(busy),     64'(0));
  endtask

  task automatic random_job(input int rows, input bit finish_on_last);
    int len;
    send(0, 0, 0, '0, 1, 0);
    for (int r = 0; r < rows; r++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2));
        send(1, i == 0, i == len - 1, IN_W'($urandom_range(0, 4095)), 0,
             finish_on_last && (r == rows - 1) && (i == len - 1));
      end
    end
    if (!finish_on_last) send(0, 0, 0, '0, 0, 1);
    wait_done();
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = '0; zero_in = 0; last = 0; finish = 0;
    repeat (3) @(posedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 0;
    idle(2);

    // Basic 13-sample row of ones.
    send(0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 13; i++) send(1, i == 0, i == 12, IN_W'(1), 0, 0);
    send(0, 0, 0, '0, 0, 1);
    wait_done();

    // Width-1 rows back to back.
    send(0, 0, 0, '0, 1, 0);
    send(1, 1, 1, IN_W'(5), 0, 0);
    send(1, 1, 1, IN_W'(-3), 0, 0);
    send(1, 1, 1, IN_W'(0), 0, 0);
    send(1, 1, 1, IN_W'(7), 0, 1);
    wait_done();

    // Large positive and negative rows.
    send(0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 40; i++) send(1, i == 0, i == 39, IN_W'(2047), 0, 0);
    for (int i = 0; i < 40; i++) send(1, i == 0, i == 39, IN_W'(-2048), 0, 0);
    send(0, 0, 0, '0, 0, 1);
    wait_done();

    // Protocol errors: stray sample in IDLE, then finish with a row open.
    send(0, 0, 0, '0, 1, 0);
    send(1, 0, 1, IN_W'(9), 0, 0);
    idle(3);
    send(0, 0, 0, '0, 1, 0);
    send(1, 1, 0, IN_W'(3), 0, 0);
    send(1, 0, 0, IN_W'(4), 0, 0);
    send(0, 0, 0, '0, 0, 1);
    wait_done();
    send(0, 0, 0, '0, 1, 0);
    idle(2);

    // Randomized jobs.
    for (int j = 0; j < 6; j++) random_job($urandom_range(1, 4), j[0]);

    // Reset two cycles after a closing sample.
    send(0, 0, 0, '0, 1, 0);
    send(1, 1, 0, IN_W'(10), 0, 0);
    send(1, 0, 1, IN_W'(20), 0, 0);
    idle(1);
    rst = 1;
    repeat (6) begin
      check_zero_outputs("midreset");
    end
    @(posedge clk);
    #1;
    rst = 0;
    idle(1);
    send(1, 1, 1, IN_W'(11), 0, 0);
    send(1, 1, 1, IN_W'(-12), 0, 1);
    wait_done();

    // Address wrap across the full row space.
    send(0, 0, 0, '0, 1, 0);
    for (int i = 0; i < (1 << ADDR_W) + 1; i++)
      send(1, 1, 1, IN_W'($urandom_range(0, 4095)), 0, i == (1 << ADDR_W));
    wait_done();

    idle(4);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
